// File: rtl/divisor_sequencial.sv
// Multi-cycle 8-bit restoring divider: one quotient bit per clock through a shared subtractor.
// Build option: define DIVISOR_SIGNED_EN for two's-complement operands (truncating division).

module subtrator_8bits (
  input  logic [7:0] A,
  input  logic [7:0] B,
  output logic [7:0] S,
  output logic       C_out
);
  // The 9th bit of the zero-extended difference is the borrow (A < B).
  assign {C_out, S} = {1'b0, A} - {1'b0, B};
endmodule

module divisor_sequencial #(
  parameter logic [7:0] ZERO_Q = 8'hFF
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       START,
  input  logic [7:0] A,
  input  logic [7:0] B,
  output logic [7:0] Q,
  output logic [7:0] R,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR
);

  typedef enum logic {OCIOSO, CALC} state_t;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_rem, r_quo, r_div, r_q, r_r;
  logic [2:0] r_cnt;
  logic       r_busy, r_done, r_err;

  logic [7:0] w_rem_nxt, w_quo_nxt, w_div_nxt, w_q_nxt, w_r_nxt;
  logic [2:0] w_cnt_nxt;
  logic       w_busy_nxt, w_done_nxt, w_err_nxt;

  logic [7:0] w_shifted, w_diff, w_rem_step, w_quo_step;
  logic       w_borrow;

  assign w_shifted = {r_rem[6:0], r_quo[7]};

  subtrator_8bits u_sub (
    .A     (w_shifted),
    .B     (r_div),
    .S     (w_diff),
    .C_out (w_borrow)
  );

  assign w_rem_step = w_borrow ? w_shifted : w_diff;
  assign w_quo_step = {r_quo[6:0], ~w_borrow};

  logic [7:0] w_ld_a, w_ld_b, w_q_final, w_r_final;
  logic       w_err_final;

`ifdef DIVISOR_SIGNED_EN
  logic       r_neg_q, r_neg_r, r_ovf;
  logic       w_neg_q_nxt, w_neg_r_nxt, w_ovf_nxt;
  logic [7:0] w_neg_a, w_neg_b, w_neg_qs, w_neg_rs;
  logic       w_nc_a, w_nc_b, w_nc_q, w_nc_r;

  subtrator_8bits u_neg_a (.A(8'h00), .B(A),          .S(w_neg_a),  .C_out(w_nc_a));
  subtrator_8bits u_neg_b (.A(8'h00), .B(B),          .S(w_neg_b),  .C_out(w_nc_b));
  subtrator_8bits u_neg_q (.A(8'h00), .B(w_quo_step), .S(w_neg_qs), .C_out(w_nc_q));
  subtrator_8bits u_neg_r (.A(8'h00), .B(w_rem_step), .S(w_neg_rs), .C_out(w_nc_r));

  // 0-8'h80 wraps back to 8'h80, which is still the correct unsigned magnitude 128.
  assign w_ld_a      = A[7] ? w_neg_a : A;
  assign w_ld_b      = B[7] ? w_neg_b : B;
  assign w_q_final   = r_neg_q ? w_neg_qs : w_quo_step;
  assign w_r_final   = r_neg_r ? w_neg_rs : w_rem_step;
  assign w_err_final = r_ovf;
`else
  assign w_ld_a      = A;
  assign w_ld_b      = B;
  assign w_q_final   = w_quo_step;
  assign w_r_final   = w_rem_step;
  assign w_err_final = 1'b0;
`endif

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_quo_nxt   = r_quo;
    w_div_nxt   = r_div;
    w_cnt_nxt   = r_cnt;
    w_q_nxt     = r_q;
    w_r_nxt     = r_r;
    w_busy_nxt  = r_busy;
    w_err_nxt   = r_err;
    w_done_nxt  = 1'b0;
`ifdef DIVISOR_SIGNED_EN
    w_neg_q_nxt = r_neg_q;
    w_neg_r_nxt = r_neg_r;
    w_ovf_nxt   = r_ovf;
`endif
    case (r_state)
      OCIOSO: begin
        if (START) begin
          w_div_nxt = w_ld_b;
          w_quo_nxt = w_ld_a;
          w_rem_nxt = 8'h00;
          w_cnt_nxt = 3'd7;
          w_err_nxt = 1'b0;
`ifdef DIVISOR_SIGNED_EN
          w_neg_q_nxt = A[7] ^ B[7];
          w_neg_r_nxt = A[7];
          w_ovf_nxt   = (A == 8'h80) && (B == 8'hFF);
`endif
          if (B != 8'h00) begin
            w_state_nxt = CALC;
            w_busy_nxt  = 1'b1;
          end else begin
            w_q_nxt    = ZERO_Q;
            w_r_nxt    = A;
            w_err_nxt  = 1'b1;
            w_done_nxt = 1'b1;
          end
        end
      end
      CALC: begin
        w_rem_nxt = w_rem_step;
        w_quo_nxt = w_quo_step;
        w_cnt_nxt = r_cnt - 3'd1;
        // Last quotient bit: publish the post-step values directly.
        if (r_cnt == 3'd0) begin
          w_q_nxt     = w_q_final;
          w_r_nxt     = w_r_final;
          w_err_nxt   = w_err_final;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = OCIOSO;
        end
      end
      default: w_state_nxt = OCIOSO;
    endcase
  end

  // NOTE: reset is synchronous and sequential state uses non-blocking assignments only.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state <= OCIOSO;
      r_rem   <= 8'h00;
      r_quo   <= 8'h00;
      r_div   <= 8'h00;
      r_cnt   <= 3'd0;
      r_q     <= 8'h00;
      r_r     <= 8'h00;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
`ifdef DIVISOR_SIGNED_EN
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_ovf   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
      r_quo   <= w_quo_nxt;
      r_div   <= w_div_nxt;
      r_cnt   <= w_cnt_nxt;
      r_q     <= w_q_nxt;
      r_r     <= w_r_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
`ifdef DIVISOR_SIGNED_EN
      r_neg_q <= w_neg_q_nxt;
      r_neg_r <= w_neg_r_nxt;
      r_ovf   <= w_ovf_nxt;
`endif
    end
  end

  assign Q    = r_q;
  assign R    = r_r;
  assign BUSY = r_busy;
  assign DONE = r_done;
  assign ERR  = r_err;

endmodule

// File: tb/tb_divisor_sequencial.sv
// Self-checking bench for divisor_sequencial: transaction-level arithmetic model plus directed literals.
// Signed-mode vectors are compiled in when DIVISOR_SIGNED_EN is defined.

module tb_divisor_sequencial;

  localparam logic [7:0] ZERO_Q = 8'hFF;

  logic       clk, rst_n, start;
  logic [7:0] a, b, q, r;
  logic       busy, done, err;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  divisor_sequencial #(.ZERO_Q(ZERO_Q)) dut (
    .CLK(clk), .RST_N(rst_n), .START(start), .A(a), .B(b),
    .Q(q), .R(r), .BUSY(busy), .DONE(done), .ERR(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic reference for a non-zero divisor.
  function automatic void model_div(input logic [7:0] da, input logic [7:0] db,
                                    output logic [7:0] mq, output logic [7:0] mr,
                                    output logic me);
`ifdef DIVISOR_SIGNED_EN
    int sa, sb;
    sa = int'($signed(da));
    sb = int'($signed(db));
    if (sa == -128 && sb == -1) begin
      mq = 8'h80; mr = 8'h00; me = 1'b1;
    end else begin
      mq = 8'(sa / sb); mr = 8'(sa % sb); me = 1'b0;
    end
`else
    mq = 8'(int'(da) / int'(db));
    mr = 8'(int'(da) % int'(db));
    me = 1'b0;
`endif
  endfunction

  // Handshake model: accept when idle, result appears 8 edges after accept.
  logic [7:0] m_q, m_r, p_q, p_r;
  logic       m_busy, m_done, m_err, p_err;
  int         m_left;

  always @(posedge clk) begin
    m_done = 1'b0;
    if (!rst_n) begin
      m_q = 8'h00; m_r = 8'h00; m_busy = 1'b0; m_err = 1'b0; m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_q = p_q; m_r = p_r; m_err = p_err; m_done = 1'b1; m_busy = 1'b0;
      end
    end else if (start) begin
      m_err = 1'b0;
      if (b == 8'h00) begin
        m_q = ZERO_Q; m_r = a; m_err = 1'b1; m_done = 1'b1;
      end else begin
        model_div(a, b, p_q, p_r, p_err);
        m_left = 8;
        m_busy = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_busy", busy, m_busy);
      check("cyc_done", done, m_done);
      check("cyc_q", q, m_q);
      check("cyc_r", r, m_r);
      check("cyc_err", err, m_err);
    end
  end

  // Called at a negedge; the accept edge is the next posedge.
  task automatic issue(input logic [7:0] ia, input logic [7:0] ib);
    a = ia; b = ib; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    check("done_seen", done, 1);
  endtask

  task automatic run(input logic [7:0] ia, input logic [7:0] ib, input logic [7:0] eq,
                     input logic [7:0] er, input logic ee, input int elat);
    int lat;
    issue(ia, ib);
    if (ib != 8'h00) check("busy_after_accept", busy, 1);
    wait_done(lat);
    check("lat", lat, elat);
    check("q", q, eq);
    check("r", r, er);
    check("err", err, ee);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    rst_n = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00;
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    check("rst_q", q, 0);
    check("rst_r", r, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    @(negedge clk);

`ifndef DIVISOR_SIGNED_EN
    run(8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 9);
    run(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 9);
    run(8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 9);
    run(8'd0, 8'd3, 8'd0, 8'd0, 1'b0, 9);
`else
    run(8'h9C, 8'd7, 8'hF2, 8'hFE, 1'b0, 9);
    run(8'd100, 8'hF9, 8'hF2, 8'h02, 1'b0, 9);
    run(8'h80, 8'hFF, 8'h80, 8'h00, 1'b1, 9);
    run(8'hF7, 8'hFD, 8'h03, 8'h00, 1'b0, 9);
`endif

    run(8'd42, 8'd0, 8'hFF, 8'd42, 1'b1, 1);
    check("zero_busy", busy, 0);

    // START while busy is ignored.
    issue(8'd100, 8'd10);
    repeat (2) @(negedge clk);
    a = 8'd9; b = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    check("ign_q", q, 10);
    check("ign_r", r, 0);

    // Accept in the DONE cycle.
    run(8'd9, 8'd3, 8'd3, 8'd0, 1'b0, 9);

    // START held high: completions every 9 cycles.
    a = 8'd20; b = 8'd4; start = 1'b1;
    wait_done(lat);
    @(negedge clk);
    check("held_done_clr", done, 0);
    wait_done(lat);
    start = 1'b0;
    check("held_period", lat, 9);
    check("held_q", q, 5);
    check("held_r", r, 0);

    // Reset in the middle of a division.
    @(negedge clk);
    issue(8'd200, 8'd7);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_q", q, 0);
    check("abort_r", r, 0);
    check("abort_busy", busy, 0);
    check("abort_err", err, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("abort_no_done", done, 0);
    end
    run(8'd50, 8'd5, 8'd10, 8'd0, 1'b0, 9);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
